decoder_stream_host: RTL and testbench

DECODER_STREAM_HOST -- requirements
Module: decoder_stream_host

---
 rtl/decoder_stream_host.sv | 167 ++++++++++++++++
 tb/tb_decoder_stream_host.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_stream_host.sv
// Host-side byte streamer for the decoder: sends a header and the latched
// measurement image, then collects the stats and correction response bytes.
module decoder_stream_host #(
    parameter int          GRID_WIDTH_X   = 4,
    parameter int          GRID_WIDTH_Z   = 1,
    parameter int          GRID_WIDTH_U   = 5,
    parameter logic [7:0]  HEADER_BYTE    = 8'h01,
    parameter int          TIMEOUT_CYCLES = 65535,
    localparam int ROUNDS = GRID_WIDTH_U / 2,
    localparam int MB     = (GRID_WIDTH_X * GRID_WIDTH_Z + 7) / 8,
    localparam int CW     = (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1
                            + GRID_WIDTH_X * GRID_WIDTH_Z,
    localparam int CB     = (CW + 7) / 8,
    localparam int NMEAS  = ROUNDS * MB,
    localparam int NCORR  = ROUNDS * CB
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NMEAS*8-1:0]   meas_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           iteration_count,
    output logic [15:0]          cycle_count,
    output logic [NCORR*8-1:0]   correction_out,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE, SEND_HDR, SEND_MEAS, RECV_STATS, RECV_CORR, FINISH
    } state_t;

    localparam logic [15:0] LAST_MEAS = 16'(NMEAS - 1);
    localparam logic [15:0] LAST_CORR = 16'(NCORR - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [NMEAS*8-1:0]     r_meas;
    logic [15:0]            r_tx_cnt;
    logic [15:0]            r_rx_cnt;
    logic [15:0]            r_idle_cnt;
    logic                   r_timeout;
    logic [7:0]             r_iter;
    logic [15:0]            r_cyc;
    logic [NCORR*8-1:0]     r_corr;
    logic                   w_tx_hs;
    logic                   w_rx_hs;
    logic                   w_rx_phase;
    logic                   w_idle_expire;
    logic [7:0]             w_meas_byte;

    // Valid/ready: a byte moves on any rising edge where valid and ready are both high;
    // the sender holds data stable while valid is high and ready is low.
    assign w_rx_phase      = (r_state == RECV_STATS) || (r_state == RECV_CORR);
    assign tx_valid        = (r_state == SEND_HDR) || (r_state == SEND_MEAS);
    assign rx_ready        = w_rx_phase;
    assign busy            = (r_state != IDLE);
    assign done            = (r_state == FINISH);
    assign error           = done && r_timeout;
    assign w_tx_hs         = tx_valid && tx_ready;
    assign w_rx_hs         = rx_valid && rx_ready;
    assign w_idle_expire   = w_rx_phase && !w_rx_hs && (r_idle_cnt == TO_LAST);
    assign iteration_count = r_iter;
    assign cycle_count     = r_cyc;
    assign correction_out  = r_corr;
    assign o_dbg_state     = r_state;

    always_comb begin
        w_meas_byte = '0;
        for (int k = 0; k < NMEAS; k++) begin
            if (r_tx_cnt == 16'(k)) w_meas_byte = r_meas[8*k +: 8];
        end
    end

    always_comb begin
        tx_data = '0;
        case (r_state)
            SEND_HDR:  tx_data = HEADER_BYTE;
            SEND_MEAS: tx_data = w_meas_byte;
            default:   tx_data = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (start) w_next = SEND_HDR;
            SEND_HDR:   if (w_tx_hs) w_next = SEND_MEAS;
            SEND_MEAS:  if (w_tx_hs && r_tx_cnt == LAST_MEAS) w_next = RECV_STATS;
            RECV_STATS: begin
                if (w_rx_hs && r_rx_cnt == 16'd2) w_next = RECV_CORR;
                else if (w_idle_expire)           w_next = FINISH;
            end
            RECV_CORR: begin
                if (w_rx_hs && r_rx_cnt == LAST_CORR) w_next = FINISH;
                else if (w_idle_expire)               w_next = FINISH;
            end
            FINISH:     w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_meas     <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
            r_iter     <= '0;
            r_cyc      <= '0;
            r_corr     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_meas     <= meas_data;
                        r_tx_cnt   <= '0;
                        r_rx_cnt   <= '0;
                        r_idle_cnt <= '0;
                        r_timeout  <= 1'b0;
                        r_iter     <= '0;
                        r_cyc      <= '0;
                        r_corr     <= '0;
                    end
                end
                SEND_MEAS: begin
                    if (w_tx_hs) r_tx_cnt <= r_tx_cnt + 16'd1;
                end
                RECV_STATS, RECV_CORR: begin
                    if (w_rx_hs) begin
                        r_idle_cnt <= '0;
                        // The counter restarts at zero to index the correction bytes.
                        if (r_state == RECV_STATS && r_rx_cnt == 16'd2) r_rx_cnt <= '0;
                        else if (r_rx_cnt != 16'hFFFF)                 r_rx_cnt <= r_rx_cnt + 16'd1;
                        if (r_state == RECV_STATS) begin
                            case (r_rx_cnt)
                                16'd0:   r_iter       <= rx_data;
                                16'd1:   r_cyc[15:8]  <= rx_data;
                                default: r_cyc[7:0]   <= rx_data;
                            endcase
                        end else begin
                            for (int j = 0; j < NCORR; j++) begin
                                if (r_rx_cnt == 16'(j)) r_corr[8*j +: 8] <= rx_data;
                            end
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                        if (w_idle_expire) r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_stream_host.sv
// Directed-plus-random bench for decoder_stream_host; inputs change and outputs
// are sampled on the falling edge so every rising edge sees settled values.
module tb_decoder_stream_host;

    localparam int         NMEAS = 2;
    localparam int         NCORR = 4;
    localparam int         NRESP = 3 + NCORR;
    localparam int         TMO   = 10;
    localparam logic [7:0] HDR   = 8'h01;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [15:0]           meas_data;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [7:0]            iteration_count;
    logic [15:0]           cycle_count;
    logic [31:0]           correction_out;
    logic [2:0]            dbg_state;

    int                    n_cmp  = 0;
    int                    n_fail = 0;
    logic [7:0]            exp_q[$];
    logic [7:0]            resp[NRESP];
    int                    tx_cycles;

    decoder_stream_host #(
        .GRID_WIDTH_X(4), .GRID_WIDTH_Z(1), .GRID_WIDTH_U(5),
        .HEADER_BYTE(HDR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .meas_data(meas_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .error(error),
        .iteration_count(iteration_count), .cycle_count(cycle_count),
        .correction_out(correction_out), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill_resp();
        for (int i = 0; i < NRESP; i++) resp[i] = 8'($urandom);
    endtask

    // Streams header + image; expected bytes come from slicing the image in order.
    task automatic send_phase(input logic [15:0] m, input int mode, input bit pre_started);
        logic [7:0] stall_b;
        bit         stall;
        int         n_hs;
        int         cyc;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int k = 0; k < NMEAS; k++) exp_q.push_back(m[8*k +: 8]);
        if (!pre_started) begin
            meas_data = m;
            start = 1'b1;
            step();
            start = 1'b0;
            meas_data = 16'($urandom);
            chk("busy_after_start", 32'(busy), 32'd1);
        end
        n_hs = 0; cyc = 0; stall = 1'b0; stall_b = '0;
        while (n_hs < NMEAS + 1 && cyc < 100) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            start    = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            chk("tx_valid", 32'(tx_valid), 32'd1);
            chk("rx_ready_in_tx", 32'(rx_ready), 32'd0);
            if (stall) chk("tx_stable", 32'(tx_data), 32'(stall_b));
            if (tx_ready) begin
                chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                n_hs++;
            end
            stall   = !tx_ready;
            stall_b = tx_data;
            cyc++;
            step();
        end
        tx_cycles = cyc;
        start    = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        chk("tx_count", 32'(n_hs), 32'(NMEAS + 1));
        chk("tx_valid_after", 32'(tx_valid), 32'd0);
        chk("rx_ready_after", 32'(rx_ready), 32'd1);
    endtask

    task automatic recv_phase(input int n_bytes, input int gap_max);
        int g;
        for (int i = 0; i < n_bytes; i++) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                chk("rx_ready_wait", 32'(rx_ready), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                step();
            end
            rx_valid = 1'b1;
            rx_data  = resp[i];
            chk("rx_ready", 32'(rx_ready), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            step();
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish_check();
        logic [31:0] corr_exp;
        corr_exp = '0;
        for (int j = 0; j < NCORR; j++) corr_exp = corr_exp | (32'(resp[3+j]) << (8 * j));
        chk("done_pulse", 32'(done), 32'd1);
        chk("error_ok", 32'(error), 32'd0);
        chk("iteration_count", 32'(iteration_count), 32'(resp[0]));
        chk("cycle_count", 32'(cycle_count), {16'd0, resp[1], resp[2]});
        chk("correction_out", correction_out, corr_exp);
    endtask

    task automatic after_finish();
        step();
        chk("done_cleared", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic full_txn(input logic [15:0] m, input int mode, input int gap_max);
        fill_resp();
        send_phase(m, mode, 1'b0);
        recv_phase(NRESP, gap_max);
        finish_check();
        after_finish();
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_txv"},   32'(tx_valid), 32'd0);
        chk({tag, "_rxr"},   32'(rx_ready), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(error), 32'd0);
        chk({tag, "_txd"},   32'(tx_data), 32'd0);
        chk({tag, "_iter"},  32'(iteration_count), 32'd0);
        chk({tag, "_cyc"},   32'(cycle_count), 32'd0);
        chk({tag, "_corr"},  correction_out, 32'd0);
    endtask

    initial begin
        logic [15:0] m2;
        reset = 1'b1; start = 1'b0; meas_data = '0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = '0;
        step(); step();
        reset_outputs_check("reset");
        reset = 1'b0;
        step();

        // Reference transaction with fixed image and response bytes.
        send_phase(16'hA55A, 0, 1'b0);
        chk("tx_consecutive", 32'(tx_cycles), 32'd3);
        resp = '{8'h03, 8'h00, 8'h2A, 8'h11, 8'h22, 8'h33, 8'h44};
        recv_phase(NRESP, 0);
        finish_check();
        chk("corr_literal", correction_out, 32'h44332211);
        chk("cyc_literal", 32'(cycle_count), 32'h002A);

        // Start during FINISH is dropped; start on the following idle cycle is taken.
        m2 = 16'($urandom);
        meas_data = m2;
        start = 1'b1;
        step();
        chk("start_in_finish_ignored", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        step();
        start = 1'b0;
        chk("start_after_finish", 32'(busy), 32'd1);
        chk("results_cleared", 32'(iteration_count), 32'd0);
        fill_resp();
        send_phase(m2, 2, 1'b1);
        recv_phase(NRESP, 2);
        finish_check();
        after_finish();

        // Toggled tx_ready stalls every other cycle.
        full_txn(16'h5AA5, 1, 1);

        for (int t = 0; t < 5; t++) full_txn(16'($urandom), $urandom_range(0, 2), 4);

        // Response stops after the stats bytes.
        fill_resp();
        send_phase(16'($urandom), 2, 1'b0);
        recv_phase(3, 2);
        for (int i = 1; i <= TMO; i++) begin
            step();
            if (i < TMO) begin
                chk("timeout_early", 32'(done), 32'd0);
                chk("timeout_busy", 32'(busy), 32'd1);
            end
        end
        chk("timeout_done", 32'(done), 32'd1);
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_iter", 32'(iteration_count), 32'(resp[0]));
        chk("timeout_cyc", 32'(cycle_count), {16'd0, resp[1], resp[2]});
        after_finish();
        full_txn(16'($urandom), 0, 3);

        // Reset in the middle of the correction bytes.
        fill_resp();
        send_phase(16'($urandom), 2, 1'b0);
        recv_phase(5, 2);
        reset = 1'b1;
        rx_valid = 1'b1;
        step();
        reset_outputs_check("abort");
        reset = 1'b0;
        rx_valid = 1'b0;
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        full_txn(16'($urandom), 2, 3);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_over_start", 32'(busy), 32'd0);
        step();
        chk("reset_over_start_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
